// File: rtl/search_serial_launch_tx.sv
// search_serial_launch_tx
//
// Framed serial transmitter. It takes a parallel word through a valid/ready
// handshake and shifts it out on a single line in this order: a start bit (0),
// the data bits LSB-first, an optional even-parity bit, and a stop bit (1).
// Each bit is held for BIT_CYCLES clock cycles. The line idles high.
//
// Parameters:
//   DATA_W      payload width in bits (>= 2)
//   BIT_CYCLES  clock cycles per serial bit (>= 1)
//
// Configuration macro:
//   SEARCH_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                        last data bit and the stop bit.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any frame in flight
//   in_data   payload, captured only on an accepted handshake
//   in_valid  upstream has a word
//   in_ready  block is idle and can take a word (combinational from state/rst)
//   out_ser   registered serial line
//   out_busy  registered, high while a frame is in progress
//   out_done  registered one-cycle pulse in the cycle after the stop bit ends

module search_serial_launch_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_ser,
    output logic              out_busy,
    output logic              out_done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(DATA_W);

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SEARCH_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cyc_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg;
`ifdef SEARCH_TX_PARITY_EN
    logic              parity_bit;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Ready depends only on state and rst, so no combinational path exists
    // from in_valid or in_data to any output.
    assign in_ready = (state == IDLE) && !rst;

    wire bit_end = (cyc_cnt == CYC_LAST);

    // out_ser is loaded with the value of the bit the FSM is entering, so it
    // changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_ser   <= 1'b1;
            out_busy  <= 1'b0;
            out_done  <= 1'b0;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef SEARCH_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            out_done <= 1'b0;
            case (state)
                IDLE: begin
                    // in_ready is high whenever we are here and not in reset
                    if (in_valid) begin
                        shift_reg <= in_data;
`ifdef SEARCH_TX_PARITY_EN
                        // Parity is taken at capture because the shift
                        // register is consumed as the bits go out.
                        parity_bit <= even_parity(in_data);
`endif
                        state    <= START;
                        out_ser  <= 1'b0;
                        out_busy <= 1'b1;
                        cyc_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        out_ser <= shift_reg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef SEARCH_TX_PARITY_EN
                            state   <= PARITY;
                            out_ser <= parity_bit;
`else
                            state   <= STOP;
                            out_ser <= 1'b1;
`endif
                        end else begin
                            // Next bit to send is the one moving into bit 0
                            bit_cnt   <= bit_cnt + BW'(1);
                            shift_reg <= shift_reg >> 1;
                            out_ser   <= shift_reg[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

`ifdef SEARCH_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= STOP;
                        out_ser <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        cyc_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                        out_ser  <= 1'b1;
                        out_busy <= 1'b0;
                        out_done <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    out_ser  <= 1'b1;
                    out_busy <= 1'b0;
                    cyc_cnt  <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_search_serial_launch_tx.sv
// Testbench for search_serial_launch_tx. Two instances are used: one with
// DATA_W=8, BIT_CYCLES=4 and one with DATA_W=8, BIT_CYCLES=1. The expected
// line value in every cycle of a frame is computed from the frame layout
// (start, data LSB-first, optional parity, stop) by plain arithmetic.

module tb_search_serial_launch_tx;

    localparam int DW = 8;
    localparam int BC = 4;
`ifdef SEARCH_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          out_ser;
    logic          out_busy;
    logic          out_done;

    logic [DW-1:0] in_data1;
    logic          in_valid1;
    logic          in_ready1;
    logic          out_ser1;
    logic          out_busy1;
    logic          out_done1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    search_serial_launch_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_ser  (out_ser),
        .out_busy (out_busy),
        .out_done (out_done)
    );

    search_serial_launch_tx #(.DATA_W(DW), .BIT_CYCLES(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .out_ser  (out_ser1),
        .out_busy (out_busy1),
        .out_done (out_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line value in cycle k (1-based, k=1 is the cycle after acceptance)
    // of a frame carrying d with bc cycles per bit.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int k, input int bc);
        int idx;
        idx = (k - 1) / bc;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (NB == DW + 3 && idx == DW + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ser",   out_ser,  1);
            check("idle_busy",  out_busy, 0);
            check("idle_done",  out_done, 0);
            check("idle_ready", in_ready, 1);
        end
    endtask

    // Called at a negedge with the block idle. noise: toggle in_data and
    // pulse in_valid while busy. chain: hold in_valid high with nxt during
    // the final bit so nxt is accepted in the done cycle.
    task automatic run_frame(input logic [DW-1:0] d, input bit noise,
                             input bit chain, input logic [DW-1:0] nxt);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 1; k <= NB * BC; k++) begin
            @(negedge clk);
            check($sformatf("ser_%02h_k%0d", d, k), out_ser, exp_bit(d, k, BC));
            check("frame_busy",  out_busy, 1);
            check("frame_done",  out_done, 0);
            check("frame_ready", in_ready, 0);
            if (k == NB * BC) begin
                in_valid = chain;
                in_data  = chain ? nxt : DW'($urandom);
            end else if (noise) begin
                in_valid = 1'($urandom);
                in_data  = DW'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("done_pulse", out_done, 1);
        check("done_busy",  out_busy, 0);
        check("done_ser",   out_ser,  1);
        check("done_ready", in_ready, 1);
        if (!chain) in_valid = 1'b0;
    endtask

    // Start a frame and assert rst for one edge after cycle 'at'.
    task automatic reset_frame(input logic [DW-1:0] d, input int at);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 1; k <= at; k++) begin
            @(negedge clk);
            check("rf_ser", out_ser, exp_bit(d, k, BC));
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rf_ser_after",   out_ser,  1);
        check("rf_busy_after",  out_busy, 0);
        check("rf_done_after",  out_done, 0);
        check("rf_ready_inrst", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rf_ready_post", in_ready, 1);
        check("rf_done_post",  out_done, 0);
        check("rf_busy_post",  out_busy, 0);
    endtask

    task automatic run_frame1(input logic [DW-1:0] d);
        in_valid1 = 1'b1;
        in_data1  = d;
        for (int k = 1; k <= NB; k++) begin
            @(negedge clk);
            check($sformatf("bc1_ser_%02h_k%0d", d, k), out_ser1, exp_bit(d, k, 1));
            check("bc1_busy", out_busy1, 1);
            check("bc1_done", out_done1, 0);
            in_valid1 = 1'b0;
            in_data1  = DW'($urandom);
        end
        @(negedge clk);
        check("bc1_done_pulse", out_done1, 1);
        check("bc1_done_ser",   out_ser1,  1);
        check("bc1_done_ready", in_ready1, 1);
        @(negedge clk);
        check("bc1_done_clear", out_done1, 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] nd;
        bit            noise;
        bit            chain;

        in_valid  = 1'b0;
        in_data   = '0;
        in_valid1 = 1'b0;
        in_data1  = '0;
        rst       = 1'b1;

        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_ser",   out_ser,  1);
        check("rst_busy",  out_busy, 0);
        check("rst_done",  out_done, 0);
        check("rst_ser1",  out_ser1, 1);
        in_valid = 1'b0;
        rst = 1'b0;
        idle(2);

        run_frame(8'hA5, 1'b0, 1'b0, '0);
        idle(2);

        run_frame(8'h3C, 1'b0, 1'b1, 8'hC3);
        run_frame(8'hC3, 1'b0, 1'b0, '0);
        idle(1);

        reset_frame(8'hFF, 10);
        idle(3);

        run_frame(8'h5A, 1'b1, 1'b0, '0);
        idle(2);

        run_frame1(8'h01);
        run_frame1(8'hB6);

        d = DW'($urandom);
        for (int it = 0; it < 20; it++) begin
            noise = 1'($urandom);
            chain = (it != 19) && ($urandom_range(0, 2) == 0);
            nd    = DW'($urandom);
            run_frame(d, noise, chain, nd);
            if (chain) begin
                d = nd;
            end else begin
                idle($urandom_range(1, 3));
                d = DW'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
